digits_bcd_conv: RTL and testbench

//  Sequential binary-to-packed-BCD converter sitting directly upstream of the 8-digit
//  7-segment scanner. Takes an unsigned binary value, converts it by shift-and-add-3
//  (one bit per clock) and presents a packed BCD word (digit 0 in [3:0]) plus a one-cycle

---
 rtl/digits_pkg.sv | 22 ++
 rtl/bcd_add3.sv | 11 +
 rtl/digits_bcd_conv.sv | 147 ++++++++++++++
 tb/tb_digits_bcd_conv.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digits_pkg.sv
// Shared constants, FSM state encoding and saturation helper for the binary-to-BCD converter.
package digits_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Largest value representable in 'digits' decimal digits (10^digits - 1).
    function automatic logic [63:0] bcd_max(input int digits);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < digits; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-digit correction step of shift-and-add-3: digits of 5 or more get +3 before the shift.
module bcd_add3
    import digits_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);

    assign adj = (digit >= 4'd5) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/digits_bcd_conv.sv
// Sequential binary-to-packed-BCD converter (one bit per clock) feeding the 7-segment scanner.
// Optional leading-zero mask on blank_o when DIGITS_BCD_BLANK_EN is defined.
module digits_bcd_conv
    import digits_pkg::*;
#(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o,
    output logic [DIGITS-1:0]     blank_o
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0]       BCD_MAX   = bcd_max(DIGITS);
    localparam logic [ACC_W-1:0]  ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
    localparam logic [1:0] S_DONE  = DONE;

    generate
        if (BIN_W > ACC_W - 1) begin : g_bad_width
            $error("digits_bcd_conv: BIN_W must not exceed 4*DIGITS-1");
        end
        if (DIGITS > 19 || DIGITS < 1) begin : g_bad_digits
            $error("digits_bcd_conv: DIGITS must be in 1..19");
        end
        if (BIN_W > 64 || BIN_W < 1) begin : g_bad_bin
            $error("digits_bcd_conv: BIN_W must be in 1..64");
        end
    endgenerate

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [BIN_W-1:0] bin_reg;
    logic             ovf_pend_reg;
    logic [ACC_W-1:0] bcd_reg;
    logic             ovf_reg;
    logic             out_valid_reg;

    logic [ACC_W-1:0]       acc_adj;
    logic [ACC_W+BIN_W-1:0] shifted_next;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .digit (acc_reg[gi*DIGIT_W +: DIGIT_W]),
                .adj   (acc_adj[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    assign shifted_next = {acc_adj, bin_reg} << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            acc_reg       <= '0;
            bin_reg       <= '0;
            ovf_pend_reg  <= 1'b0;
            bcd_reg       <= '0;
            ovf_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        bin_reg      <= bin_i;
                        acc_reg      <= '0;
                        cnt_reg      <= CNT_INIT;
                        ovf_pend_reg <= (64'(bin_i) > BCD_MAX);
                        state_reg    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    acc_reg <= shifted_next[ACC_W+BIN_W-1 -: ACC_W];
                    bin_reg <= shifted_next[BIN_W-1:0];
                    cnt_reg <= cnt_reg - CNT_LAST;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    bcd_reg       <= ovf_pend_reg ? ALL_NINES : acc_reg;
                    ovf_reg       <= ovf_pend_reg;
                    out_valid_reg <= 1'b1;
                    state_reg     <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = out_valid_reg;
    assign bcd_o     = bcd_reg;
    assign ovf_o     = ovf_reg;

`ifdef DIGITS_BCD_BLANK_EN
    // zero_up[i]: digit i and every digit above it are zero.
    logic [DIGITS-1:0] zero_up;
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_reg;

    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_blank
            if (gi == DIGITS - 1) begin : g_top
                assign zero_up[gi] = (acc_reg[gi*DIGIT_W +: DIGIT_W] == 4'd0);
            end else begin : g_mid
                assign zero_up[gi] = (acc_reg[gi*DIGIT_W +: DIGIT_W] == 4'd0) && zero_up[gi+1];
            end
        end
    endgenerate

    // A saturated result or an all-zero value shows every digit.
    assign blank_next = (ovf_pend_reg || zero_up[0]) ? '0 : (zero_up & ~DIGITS'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_reg <= '0;
        end else if (state_reg == S_DONE) begin
            blank_reg <= blank_next;
        end
    end

    assign blank_o = blank_reg;
`else
    assign blank_o = '0;
`endif

endmodule

// File: tb/tb_digits_bcd_conv.sv
// Self-checking bench for digits_bcd_conv: arithmetic reference model plus directed literal checks.
module tb_digits_bcd_conv;

    localparam int BIN_W   = 27;
    localparam int DIGITS  = 8;
    localparam int LATENCY = BIN_W + 1;
`ifdef DIGITS_BCD_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BIN_W-1:0]  bin_i = '0;
    logic              out_valid;
    logic [31:0]       bcd_o;
    logic              ovf_o;
    logic [7:0]        blank_o;

    digits_bcd_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_i     (bin_i),
        .out_valid (out_valid),
        .bcd_o     (bcd_o),
        .ovf_o     (ovf_o),
        .blank_o   (blank_o)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // Reference model state: cycles until the pending result appears, and expected outputs.
    int          busy = 0;
    logic        exp_ov = 1'b0;
    logic [31:0] exp_bcd = '0;
    logic        exp_ovf = 1'b0;
    logic [7:0]  exp_blank = '0;
    logic [31:0] pend_bcd = '0;
    logic        pend_ovf = 1'b0;
    logic [7:0]  pend_blank = '0;

    function automatic logic [31:0] to_bcd(input longint v);
        logic [31:0] r;
        longint x;
        r = '0;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] blank_of(input longint v, input bit ovf);
        logic [7:0] m;
        longint p;
        m = '0;
        p = 1;
        if (BLANK_EN && !ovf && v != 0) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (i >= 1 && v < p) m[i] = 1'b1;
                p = p * 10;
            end
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_reset();
        busy      = 0;
        exp_ov    = 1'b0;
        exp_bcd   = '0;
        exp_ovf   = 1'b0;
        exp_blank = '0;
    endtask

    task automatic model_step();
        longint v;
        bit o;
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_ov = 1'b0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    exp_ov    = 1'b1;
                    exp_bcd   = pend_bcd;
                    exp_ovf   = pend_ovf;
                    exp_blank = pend_blank;
                end
            end else if (in_valid) begin
                v          = longint'(bin_i);
                o          = (v > 99_999_999);
                busy       = LATENCY;
                pend_ovf   = o;
                pend_bcd   = o ? 32'h9999_9999 : to_bcd(v);
                pend_blank = blank_of(v, o);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy != 0 && n < 100) begin
            tick();
            n++;
        end
        check("idle_wait", 64'(busy == 0), 64'd1);
    endtask

    // Directed conversion with hand-computed expectations.
    task automatic convert(input logic [BIN_W-1:0] v, input logic [31:0] want_bcd,
                           input logic want_ovf, input logic [7:0] want_blank, input string tag);
        int n;
        int low;
        wait_idle();
        in_valid = 1'b1;
        bin_i    = v;
        tick();
        in_valid = 1'b0;
        bin_i    = BIN_W'($urandom);
        n   = 0;
        low = 0;
        while (!out_valid && n < 60) begin
            if (!in_ready) low++;
            tick();
            n++;
            if (!out_valid) begin
                bin_i    = BIN_W'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(LATENCY));
        check({tag, "_ready_low"}, 64'(low), 64'(LATENCY));
        check({tag, "_bcd"}, 64'(bcd_o), 64'(want_bcd));
        check({tag, "_ovf"}, 64'(ovf_o), 64'(want_ovf));
        check({tag, "_blank"}, 64'(blank_o), 64'(want_blank & {8{BLANK_EN}}));
        check({tag, "_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    function automatic logic [BIN_W-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return BIN_W'($urandom_range(0, 999));
            1:       return BIN_W'($urandom);
            2:       return BIN_W'($urandom_range(99_999_990, 100_000_010));
            default: return BIN_W'($urandom_range(0, 99_999_999));
        endcase
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(exp_ov));
            check("in_ready", 64'(in_ready), 64'(busy == 0));
            check("bcd_o", 64'(bcd_o), 64'(exp_bcd));
            check("ovf_o", 64'(ovf_o), 64'(exp_ovf));
            check("blank_o", 64'(blank_o), 64'(exp_blank));
        end
    end

    initial begin
        int seen;
        model_reset();
        #1;
        chk_en = 1'b1;
        repeat (3) tick();
        check("rst_bcd", 64'(bcd_o), 64'h0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        tick();

        convert(27'd12_345_678,  32'h1234_5678, 1'b0, 8'h00,        "dec12345678");
        convert(27'd0,           32'h0000_0000, 1'b0, 8'h00,        "zero");
        convert(27'd99_999_999,  32'h9999_9999, 1'b0, 8'h00,        "max");
        convert(27'd100_000_000, 32'h9999_9999, 1'b1, 8'h00,        "ovf");
        convert(27'd5,           32'h0000_0005, 1'b0, 8'b1111_1110, "five");
        convert(27'd42,          32'h0000_0042, 1'b0, 8'b1111_1100, "fortytwo");

        // in_valid held high with a new value every cycle.
        in_valid = 1'b1;
        for (int k = 0; k < 320; k++) begin
            bin_i = rand_val();
            tick();
        end
        in_valid = 1'b0;
        wait_idle();

        // Reset ten cycles into a conversion.
        in_valid = 1'b1;
        bin_i    = 27'd76_543_210;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_bcd", 64'(bcd_o), 64'h0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        repeat (3) tick();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_valid", 64'(seen), 64'd0);
        convert(27'd87_654_321, 32'h8765_4321, 1'b0, 8'h00, "after_abort");

        // Sparse random requests.
        for (int k = 0; k < 700; k++) begin
            in_valid = ($urandom_range(0, 2) == 0);
            bin_i    = rand_val();
            tick();
        end
        in_valid = 1'b0;
        wait_idle();
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
